// File: rtl/conv_pkg.sv
// Shared types for the conv datapath: partial-sum and output-byte types plus
// the signed 8-bit saturation helper used by the requantizer.
package conv_pkg;

  localparam int SUM_W = 32;

  typedef logic signed [SUM_W-1:0] sum_t;
  typedef logic signed [7:0]       ofm_byte_t;

  localparam ofm_byte_t S8_MAX = 8'sd127;
  localparam ofm_byte_t S8_MIN = 8'sh80;

  // Clamp a sign-extended wide value into the signed byte range.
  function automatic ofm_byte_t sat_s8(input logic signed [63:0] v);
    ofm_byte_t r;
    if (v > 64'(S8_MAX)) begin
      r = S8_MAX;
    end else if (v < 64'(S8_MIN)) begin
      r = S8_MIN;
    end else begin
      r = v[7:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/ofm_drain_if.sv
// Ready/valid byte stream leaving ofm_drain: requantized byte, source column
// and end-of-tile-line flag.
interface ofm_drain_if #(
  parameter int COL = 8
);
  import conv_pkg::*;

  localparam int CW = $clog2(COL);

  ofm_byte_t       ofm_data;
  logic [CW-1:0]   ofm_col;
  logic            ofm_last;
  logic            ofm_valid;
  logic            ofm_ready;

  modport master (
    output ofm_data,
    output ofm_col,
    output ofm_last,
    output ofm_valid,
    input  ofm_ready
  );

  modport slave (
    input  ofm_data,
    input  ofm_col,
    input  ofm_last,
    input  ofm_valid,
    output ofm_ready
  );

endinterface

// File: rtl/ofm_col_fifo.sv
// Per-column synchronous FIFO; head word is combinational from the read
// pointer so the arbiter can requantize it in the same cycle it pops.
module ofm_col_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout  = mem_q[rd_q[AW-1:0]];

  // Pointer next-state; clear wins over push and pop.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (clear) begin
      wr_d = {(AW+1){1'b0}};
      rd_d = {(AW+1){1'b0}};
    end else begin
      if (push) begin
        wr_d = wr_q + PTR_ONE;
      end else begin
        wr_d = wr_q;
      end
      if (pop) begin
        rd_d = rd_q + PTR_ONE;
      end else begin
        rd_d = rd_q;
      end
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q <= {(AW+1){1'b0}};
      rd_q <= {(AW+1){1'b0}};
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage array; a push while full is only issued alongside a pop.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem_q[wr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/ofm_drain.sv
// Column-FIFO output drain: round-robin arbitration, requantization to s8 and
// tile-line tagging. Build option OFM_DRAIN_ROUND_EN enables round-half-up.
module ofm_drain #(
  parameter int COL        = 8,
  parameter int OFM_WIDTH  = 32,
  parameter int TILE_LEN   = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        clear,
  input  logic [4:0]                  cfg_shift,
  input  logic                        cfg_relu,
  input  logic signed [OFM_WIDTH-1:0] sum [COL],
  input  logic [COL-1:0]              sum_valid,
  ofm_drain_if.master                 ofm,
  output logic                        err_overflow,
  output logic                        busy
);
  import conv_pkg::*;

  localparam int CW = $clog2(COL);
  localparam int TW = $clog2(TILE_LEN);
  localparam int EW = OFM_WIDTH + 1;
  localparam logic [CW-1:0] COL_LAST  = CW'(COL - 1);
  localparam logic [CW-1:0] COL_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0] TILE_LAST = TW'(TILE_LEN - 1);
  localparam logic [TW-1:0] TILE_ONE  = {{(TW-1){1'b0}}, 1'b1};

  logic signed [OFM_WIDTH-1:0] head_arr_s [COL];
  logic [COL-1:0] empty_s, full_s, push_s, pop_s;
  logic           free_s, grant_s, drop_s;
  logic [CW-1:0]  gidx_s;

  logic signed [OFM_WIDTH-1:0] head_s;
  logic signed [EW-1:0]        ext_s, rnd_s, shf_s;
  ofm_byte_t                   q_s;

  logic          valid_q, valid_d;
  ofm_byte_t     data_q,  data_d;
  logic [CW-1:0] col_q,   col_d;
  logic          last_q,  last_d;
  logic [CW-1:0] rr_q,    rr_d;
  logic          err_q,   err_d;
  logic [TW-1:0] cnt_q [COL];
  logic [TW-1:0] cnt_d [COL];

  function automatic logic [CW-1:0] rr_idx(input logic [CW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= COL) begin
      s = s - COL;
    end else begin
      s = s;
    end
    return CW'(s);
  endfunction

  for (genvar c = 0; c < COL; c++) begin : g_fifo
    ofm_col_fifo #(
      .WIDTH (OFM_WIDTH),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .clear (clear),
      .push  (push_s[c]),
      .pop   (pop_s[c]),
      .din   (sum[c]),
      .dout  (head_arr_s[c]),
      .full  (full_s[c]),
      .empty (empty_s[c])
    );
  end

  assign free_s = !valid_q || ofm.ofm_ready;

  // First non-empty column at or after rr, wrapping modulo COL.
  always_comb begin
    grant_s = 1'b0;
    gidx_s  = {CW{1'b0}};
    for (int k = 0; k < COL; k++) begin
      if (!grant_s && !empty_s[rr_idx(rr_q, k)]) begin
        grant_s = 1'b1;
        gidx_s  = rr_idx(rr_q, k);
      end else begin
        grant_s = grant_s;
      end
    end
  end

  // Pops follow the grant; a push into a full FIFO is kept only if it pops too.
  always_comb begin
    pop_s  = {COL{1'b0}};
    push_s = {COL{1'b0}};
    drop_s = 1'b0;
    for (int c = 0; c < COL; c++) begin
      pop_s[c]  = !clear && free_s && grant_s && (gidx_s == CW'(c));
      push_s[c] = !clear && sum_valid[c] && (!full_s[c] || pop_s[c]);
      drop_s    = drop_s || (!clear && sum_valid[c] && full_s[c] && !pop_s[c]);
    end
  end

  // Requantize the granted head; the extra bit keeps rounding from wrapping.
  always_comb begin
    head_s = head_arr_s[gidx_s];
    ext_s  = EW'(head_s);
`ifdef OFM_DRAIN_ROUND_EN
    if (cfg_shift != 5'd0) begin
      rnd_s = ext_s + ({{(EW-1){1'b0}}, 1'b1} << (cfg_shift - 5'd1));
    end else begin
      rnd_s = ext_s;
    end
`else
    rnd_s = ext_s;
`endif
    shf_s = rnd_s >>> cfg_shift;
    q_s   = sat_s8(64'(shf_s));
    if (cfg_relu && q_s[7]) begin
      q_s = 8'sd0;
    end else begin
      q_s = q_s;
    end
  end

  // Output register, tile counters, rr pointer and sticky overflow next-state.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    col_d   = col_q;
    last_d  = last_q;
    rr_d    = rr_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    if (clear) begin
      valid_d = 1'b0;
      data_d  = 8'sd0;
      col_d   = {CW{1'b0}};
      last_d  = 1'b0;
      rr_d    = {CW{1'b0}};
      err_d   = 1'b0;
      for (int c = 0; c < COL; c++) begin
        cnt_d[c] = {TW{1'b0}};
      end
    end else begin
      if (free_s) begin
        valid_d = grant_s;
        if (grant_s) begin
          data_d = q_s;
          col_d  = gidx_s;
          last_d = (cnt_q[gidx_s] == TILE_LAST);
          if (cnt_q[gidx_s] == TILE_LAST) begin
            cnt_d[gidx_s] = {TW{1'b0}};
          end else begin
            cnt_d[gidx_s] = cnt_q[gidx_s] + TILE_ONE;
          end
          rr_d = (gidx_s == COL_LAST) ? {CW{1'b0}} : (gidx_s + COL_ONE);
        end else begin
          data_d = data_q;
        end
      end else begin
        valid_d = valid_q;
      end
      if (drop_s) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      data_q  <= 8'sd0;
      col_q   <= {CW{1'b0}};
      last_q  <= 1'b0;
      rr_q    <= {CW{1'b0}};
      err_q   <= 1'b0;
      for (int c = 0; c < COL; c++) begin
        cnt_q[c] <= {TW{1'b0}};
      end
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      col_q   <= col_d;
      last_q  <= last_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ofm.ofm_valid = valid_q;
  assign ofm.ofm_data  = data_q;
  assign ofm.ofm_col   = col_q;
  assign ofm.ofm_last  = last_q;
  assign err_overflow  = err_q;
  assign busy          = (|(~empty_s)) || valid_q;

endmodule

// File: tb/tb_ofm_drain.sv
// Directed bench for ofm_drain: requant vector table plus round-robin,
// backpressure/overflow, clear and tile-line sequences.
module tb_ofm_drain;

  localparam int COL = 8;
`ifdef OFM_DRAIN_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  typedef struct {
    int col;
    int value;
    int shift;
    int relu;
    int exp;
  } vec_t;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              clear = 1'b0;
  logic [4:0]        cfg_shift = 5'd0;
  logic              cfg_relu = 1'b0;
  logic signed [31:0] sum [COL];
  logic [COL-1:0]    sum_valid = 8'h00;
  logic              err;
  logic              busy;

  int pass_cnt = 0;
  int total_cnt = 0;
  vec_t vecs [13];

  ofm_drain_if #(.COL(COL)) ofm_if ();

  ofm_drain #(
    .COL(COL), .OFM_WIDTH(32), .TILE_LEN(16), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .rstn(rstn), .clear(clear), .cfg_shift(cfg_shift),
    .cfg_relu(cfg_relu), .sum(sum), .sum_valid(sum_valid),
    .ofm(ofm_if), .err_overflow(err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    total_cnt++;
    if (act == exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic wait_beat(output bit got);
    int n;
    n = 0;
    got = 1'b0;
    while (n < 50 && !got) begin
      @(negedge clk);
      got = ofm_if.ofm_valid;
      n++;
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    bit got;
    for (int c = 0; c < COL; c++) sum[c] = 32'sd0;
    ofm_if.ofm_ready = 1'b1;

    vecs[0]  = '{2, 1000, 3, 0, 125};
    vecs[1]  = '{1, -5000, 2, 0, -128};
    vecs[2]  = '{1, -5000, 2, 1, 0};
    vecs[3]  = '{6, 70000, 4, 0, 127};
    vecs[4]  = '{0, 13, 2, 0, 3};
    vecs[5]  = '{0, 14, 2, 0, RND ? 4 : 3};
    vecs[6]  = '{3, -7, 1, 0, RND ? -3 : -4};
    vecs[7]  = '{5, 100, 0, 0, 100};
    vecs[8]  = '{7, -1, 5, 0, RND ? 0 : -1};
    vecs[9]  = '{4, 127, 0, 0, 127};
    vecs[10] = '{4, -129, 0, 0, -128};
    vecs[11] = '{4, 50, 0, 1, 50};
    vecs[12] = '{2, -70000, 4, 1, 0};

    // Reset state
    #12;
    chk("rst_valid", ofm_if.ofm_valid, 0);
    chk("rst_data", ofm_if.ofm_data, 0);
    chk("rst_col", ofm_if.ofm_col, 0);
    chk("rst_last", ofm_if.ofm_last, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rstn = 1'b1;

    // Single-sample requant table: latency, data, column, last
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      cfg_shift = 5'(vecs[i].shift);
      cfg_relu  = vecs[i].relu[0];
      sum[vecs[i].col] = vecs[i].value;
      sum_valid = 8'h00;
      sum_valid[vecs[i].col] = 1'b1;
      @(negedge clk);
      sum_valid = 8'h00;
      chk($sformatf("v%0d_pre_valid", i), ofm_if.ofm_valid, 0);
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), ofm_if.ofm_valid, 1);
      chk($sformatf("v%0d_data", i), ofm_if.ofm_data, vecs[i].exp);
      chk($sformatf("v%0d_col", i), ofm_if.ofm_col, vecs[i].col);
      chk($sformatf("v%0d_last", i), ofm_if.ofm_last, 0);
      @(negedge clk);
      chk($sformatf("v%0d_drained", i), ofm_if.ofm_valid, 0);
    end
    chk("table_err", err, 0);

    // Round-robin: 0,3,5 together; then 0 alone (wrap); then 1 and 0 together
    do_clear();
    cfg_shift = 5'd0;
    cfg_relu  = 1'b0;
    @(negedge clk);
    sum[0] = 10; sum[3] = 30; sum[5] = 50;
    sum_valid = 8'b0010_1001;
    @(negedge clk);
    sum_valid = 8'h00;
    for (int j = 0; j < 3; j++) begin
      wait_beat(got);
      chk($sformatf("rr1_beat%0d", j), got, 1);
      chk($sformatf("rr1_col%0d", j), ofm_if.ofm_col, (j == 0) ? 0 : ((j == 1) ? 3 : 5));
    end
    sum[0] = 11;
    sum_valid = 8'b0000_0001;
    @(negedge clk);
    sum_valid = 8'h00;
    wait_beat(got);
    chk("rr2_beat", got, 1);
    chk("rr2_col", ofm_if.ofm_col, 0);
    sum[0] = 12; sum[1] = 21;
    sum_valid = 8'b0000_0011;
    @(negedge clk);
    sum_valid = 8'h00;
    for (int j = 0; j < 2; j++) begin
      wait_beat(got);
      chk($sformatf("rr3_beat%0d", j), got, 1);
      chk($sformatf("rr3_col%0d", j), ofm_if.ofm_col, (j == 0) ? 1 : 0);
      chk($sformatf("rr3_data%0d", j), ofm_if.ofm_data, (j == 0) ? 21 : 12);
    end

    // Backpressure and overflow on column 0
    do_clear();
    ofm_if.ofm_ready = 1'b0;
    sum[0] = 5;
    sum_valid = 8'h01;
    @(negedge clk);
    sum_valid = 8'h00;
    @(negedge clk);
    chk("bp_valid", ofm_if.ofm_valid, 1);
    chk("bp_data", ofm_if.ofm_data, 5);
    for (int i = 0; i < 9; i++) begin
      sum[0] = 10 + i;
      sum_valid = 8'h01;
      @(negedge clk);
      chk($sformatf("bp_hold_data%0d", i), ofm_if.ofm_data, 5);
      chk($sformatf("bp_hold_valid%0d", i), ofm_if.ofm_valid, 1);
      chk($sformatf("bp_err%0d", i), err, (i == 8) ? 1 : 0);
    end
    sum_valid = 8'h00;
    chk("bp_busy", busy, 1);
    ofm_if.ofm_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      wait_beat(got);
      chk($sformatf("bp_beat%0d", j), got, 1);
      chk($sformatf("bp_out%0d", j), ofm_if.ofm_data, 10 + j);
    end
    @(negedge clk);
    chk("bp_empty_valid", ofm_if.ofm_valid, 0);
    chk("bp_idle_busy", busy, 0);
    chk("bp_err_sticky", err, 1);

    // Clear with a held beat and same-cycle samples
    ofm_if.ofm_ready = 1'b0;
    sum[0] = 7;
    sum_valid = 8'h01;
    @(negedge clk);
    sum_valid = 8'h00;
    @(negedge clk);
    chk("clr_pre_valid", ofm_if.ofm_valid, 1);
    clear = 1'b1;
    sum_valid = 8'hFF;
    @(negedge clk);
    clear = 1'b0;
    sum_valid = 8'h00;
    chk("clr_err", err, 0);
    chk("clr_busy", busy, 0);
    chk("clr_valid", ofm_if.ofm_valid, 0);
    @(negedge clk);
    chk("clr_discard", ofm_if.ofm_valid, 0);
    ofm_if.ofm_ready = 1'b1;

    // Tile line: 32 samples on column 4
    fork
      begin
        for (int i = 0; i < 32; i++) begin
          @(negedge clk);
          sum[4] = i;
          sum_valid = 8'h10;
        end
        @(negedge clk);
        sum_valid = 8'h00;
      end
      begin
        bit g;
        for (int j = 0; j < 32; j++) begin
          wait_beat(g);
          chk($sformatf("tile_beat%0d", j), g, 1);
          chk($sformatf("tile_data%0d", j), ofm_if.ofm_data, j);
          chk($sformatf("tile_col%0d", j), ofm_if.ofm_col, 4);
          chk($sformatf("tile_last%0d", j), ofm_if.ofm_last, (j == 15 || j == 31) ? 1 : 0);
        end
      end
    join
    @(negedge clk);
    chk("tile_done_busy", busy, 0);
    chk("tile_err", err, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ofm_drain.md
# ofm_drain

Output stage directly downstream of `conv2d_3x3`. It accepts the per-column partial sums, which arrive with no backpressure, and buffers each column in its own FIFO. A round-robin arbiter drains the FIFOs; each sum is requantized to signed 8-bit and presented on one ready/valid byte stream, tagged with its column index and an end-of-tile-line flag.

## Interface
Parameters:
- `COL`, 8: number of PE-array columns; must equal the conv core `COL`.
- `OFM_WIDTH`, 32: width of each signed input sum.
- `TILE_LEN`, 16: outputs per tile line, per column.
- `FIFO_DEPTH`, 8: entries per column FIFO; power of two, minimum 2.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rstn`, in, 1: asynchronous, active-low reset.
- `clear`, in, 1: synchronous flush pulse; flushes FIFOs, counters, pointer, error flag and output register.
- `cfg_shift`, in, 5: arithmetic right-shift amount for requantization; must be stable while `busy`.
- `cfg_relu`, in, 1: when 1, negative results become 0.
- `sum[COL]`, in, `OFM_WIDTH` each: signed sums from the conv core (`sum_t`).
- `sum_valid`, in, `COL`: per-column sample strobe.
- `ofm_data`, out, 8: requantized signed byte.
- `ofm_col`, out, `$clog2(COL)`: source column of the current beat.
- `ofm_last`, out, 1: last beat of a `TILE_LEN` line for `ofm_col`.
- `ofm_valid`, out, 1: beat valid.
- `ofm_ready`, in, 1: consumer accepts the beat.
- `err_overflow`, out, 1: sticky; set when a sample was dropped.
- `busy`, out, 1: any FIFO is non-empty, or `ofm_valid` is high.

## Operation
- **Capture:**
  - At each rising edge with `sum_valid[c]=1`, `sum[c]` is pushed into FIFO c. All columns may push in the same cycle.
  - A push is accepted when FIFO c is not full, or when FIFO c is popped in the same cycle.
  - Otherwise the sample is dropped and `err_overflow` is set.
- **Arbitration:**
  - The output register is free when `ofm_valid=0`, or when `ofm_valid & ofm_ready`.
  - When the register is free, the first non-empty FIFO is popped, searching from pointer `rr` upward modulo `COL`.
  - After a grant to column g, `rr` becomes (g+1) mod `COL`. `rr` resets to 0.
- **Requantization** (combinational on the FIFO head, registered into the output):
  1. Compute t = head >>> `cfg_shift`. The shift is arithmetic, performed at `OFM_WIDTH`+1 bits.
  2. Saturate t to the range [-128, 127].
  3. If `cfg_relu=1` and t < 0, t becomes 0.
- **Tile tracking:**
  - Each column keeps a `$clog2(TILE_LEN)`-bit counter of emitted beats.
  - `ofm_last=1` when the granted column's counter equals `TILE_LEN`-1; that counter then wraps to 0. Otherwise it increments on each grant.
- **Handshake:** `ofm_data`, `ofm_col` and `ofm_last` are held stable while `ofm_valid & !ofm_ready`. A beat is transferred on an edge where `ofm_valid & ofm_ready`.
- **Clear:**
  - `clear` has priority over all pushes and pops in the same cycle.
  - After the edge: FIFOs are empty, counters and `rr` are 0, `ofm_valid=0`, `err_overflow=0`.
  - Samples arriving in the clear cycle are discarded and do not flag an error.

## Timing
- **Reset values:** `ofm_valid`=0, `ofm_data`=0, `ofm_col`=0, `ofm_last`=0, `err_overflow`=0, `busy`=0. FIFO pointers, counters and `rr` are 0.
- **Latency:** a sample captured at edge N can be popped at edge N+1 at the earliest, so `ofm_valid` is high in cycle N+1. This assumes the FIFO was empty and the register free.
- **Throughput:** one beat per cycle with `ofm_ready` held at 1. With all `COL` columns streaming at 1 sample per cycle, FIFOs fill at rate COL-1 and overflow is expected. The consumer sizes `FIFO_DEPTH` against the conv core's burst pattern.
- **Reset mid-operation:** all state is discarded immediately. There is no partial-beat recovery.
- **`busy`:** combinational from FIFO empties and `ofm_valid`. It deasserts in the cycle after the last beat transfers.

## Configuration
- `OFM_DRAIN_ROUND_EN` defined:
  - Round-half-up is applied before the shift: when `cfg_shift`>0, 2^(`cfg_shift`-1) is added to head, then shifted.
  - The addition is carried at `OFM_WIDTH`+1 bits so it cannot wrap.
- Not defined: pure truncating arithmetic shift (floor).
- Ports and latency are identical in both builds.

## Structure
- **Shared package (`conv_pkg`, existing):** `sum_t` (signed `OFM_WIDTH`). Add:
  - `ofm_byte_t` (signed 8-bit);
  - function `sat_s8()`, saturating a signed wide value to `ofm_byte_t`;
  - localparam `S8_MAX`=127 and `S8_MIN`=-128.
- **Sub-module `ofm_col_fifo`:** synchronous FIFO with ports `push`, `pop`, `din`, `dout`, `full`, `empty`, `clear`. `dout` is combinational from the read pointer, and push-when-full-with-pop is legal. It is instantiated `COL` times via generate.
- **Top:** arbiter, requant datapath, per-column tile counters and output register live in `ofm_drain`.

## Test plan
- **Single sample:** `sum[2]`=1000, `cfg_shift`=3, `ofm_ready`=1 → one beat: `ofm_data`=125, `ofm_col`=2, `ofm_valid` high in the cycle after capture.
- **Saturation / ReLU:**
  - `sum`=-5000, shift 2 → data -128.
  - Same input with `cfg_relu`=1 → data 0.
  - `sum`=70000, shift 4 → data 127.
- **Rounding:** `sum`=13, shift 2 → data 3 with `OFM_DRAIN_ROUND_EN`, 3 without. `sum`=14, shift 2 → data 4 with the macro, 3 without.
- **Round-robin:** columns 0, 3, 5 valid in the same cycle, `ofm_ready`=1 → beats in order col 0, 3, 5. Then col 1 and col 0 arrive together → col 1 first, then col 0.
- **Backpressure / overflow:**
  - `ofm_ready`=0; push 9 samples to column 0 with `FIFO_DEPTH`=8 and the register already holding one beat.
  - Expected: beat held stable, samples 1–8 retained, `err_overflow`=1 on the dropped sample.
  - Raise `ofm_ready` → 8 beats delivered in order.
  - `clear` → `err_overflow`=0, `busy`=0.
- **Tile line:** 32 samples on column 4 with `TILE_LEN`=16 → `ofm_last`=1 exactly on the 16th and 32nd beat of column 4, and 0 on all others.
